// File: rtl/vector_fetch_sequencer.sv
// Operand read sequencer for the three-vector activation store: walks vec1 paired with vec2/vec3,
// issues dual-port read requests and tags the returning data for the MAC datapath.
module vector_fetch_sequencer #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned IDX_WIDTH  = 9,
    parameter int unsigned MAX_LEN    = 264
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IDX_WIDTH-1:0]  len,
    input  logic                  alt_sel,
    input  logic                  abort,
    output logic                  mem_ren,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr1,
    output logic [ADDR_WIDTH-1:0] mem_addr2,
    output logic                  rd_valid,
    output logic [IDX_WIDTH-1:0]  rd_index,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    localparam logic [IDX_WIDTH-1:0] MaxLenW = IDX_WIDTH'(MAX_LEN);

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [IDX_WIDTH-1:0]   len_q, len_d;
    logic                   alt_q, alt_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [IDX_WIDTH-1:0]   rd_index_q, rd_index_d;
    logic                   rd_last_q, rd_last_d;
    logic                   done_q, done_d;

    logic [IDX_WIDTH-1:0]   len_clamped;
    logic                   is_last;
    logic                   xfer;

    assign len_clamped = (len > MaxLenW) ? MaxLenW : len;
    assign is_last     = (idx_q == len_q - 1'b1);

    // abort drops the request in the same cycle so an aborted grant never becomes a transfer
    assign mem_ren = (state_q == StIssue) && !abort;
    assign xfer    = mem_ren && mem_ready;
    assign busy    = (state_q != StIdle);
    assign done    = done_q && !(abort && (state_q == StDrain));

    assign rd_valid = rd_valid_q;
    assign rd_index = rd_index_q;
    assign rd_last  = rd_last_q;

    // Fixed activation-memory map: vec1 0..255, vec2 256..511, vec3 512..767, then the 8-entry
    // tails of vec1/vec2/vec3 packed at 768/776/784.
    always_comb begin
        mem_addr1 = '0;
        mem_addr2 = '0;
        if (state_q == StIssue) begin
            if (idx_q < IDX_WIDTH'(256)) begin
                mem_addr1 = ADDR_WIDTH'(idx_q[7:0]);
                mem_addr2 = (alt_q ? ADDR_WIDTH'(512) : ADDR_WIDTH'(256))
                            + ADDR_WIDTH'(idx_q[7:0]);
            end else begin
                mem_addr1 = ADDR_WIDTH'(768) + ADDR_WIDTH'(idx_q[2:0]);
                mem_addr2 = (alt_q ? ADDR_WIDTH'(784) : ADDR_WIDTH'(776))
                            + ADDR_WIDTH'(idx_q[2:0]);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        alt_d      = alt_q;
        done_d     = 1'b0;
        rd_valid_d = xfer;
        rd_last_d  = xfer && is_last;
        rd_index_d = xfer ? idx_q : rd_index_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    len_d = len_clamped;
                    alt_d = alt_sel;
                    idx_d = '0;
                    if (len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (xfer) begin
                    idx_d = idx_q + 1'b1;
                    if (is_last) begin
                        state_d = StDrain;
                        done_d  = 1'b1;
                    end
                end
            end
            StDrain: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            len_q      <= '0;
            alt_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_index_q <= '0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            alt_q      <= alt_d;
            rd_valid_q <= rd_valid_d;
            rd_index_q <= rd_index_d;
            rd_last_q  <= rd_last_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_vector_fetch_sequencer.sv
// Self-checking bench for vector_fetch_sequencer: per-cycle comparison against a counter/queue
// model of a fetch pass, plus directed literal expectations for each scenario.
module tb_vector_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [8:0] len;
    logic       alt_sel;
    logic       abort;
    logic       mem_ren;
    logic       mem_ready;
    logic [9:0] mem_addr1;
    logic [9:0] mem_addr2;
    logic       rd_valid;
    logic [8:0] rd_index;
    logic       rd_last;
    logic       busy;
    logic       done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    vector_fetch_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .alt_sel   (alt_sel),
        .abort     (abort),
        .mem_ren   (mem_ren),
        .mem_ready (mem_ready),
        .mem_addr1 (mem_addr1),
        .mem_addr2 (mem_addr2),
        .rd_valid  (rd_valid),
        .rd_index  (rd_index),
        .rd_last   (rd_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- behavioural model ----------------
    function automatic int addr_a(input int i);
        return (i < 256) ? i : 768 + (i - 256);
    endfunction

    function automatic int addr_b(input int i, input bit alt);
        if (i < 256) return (alt ? 512 : 256) + i;
        return (alt ? 784 : 776) + (i - 256);
    endfunction

    function automatic int clamp_len(input int l);
        return (l > 264) ? 264 : l;
    endfunction

    int  m_rem;   // elements still to be requested
    int  m_next;  // index of the next request
    bit  m_alt;
    bit  m_tail;  // one-cycle wait for the last read's data
    bit  m_pv;    // read data expected this cycle
    int  m_pi;
    bit  m_pl;
    bit  m_dn;
    logic m_xfer;

    assign m_xfer = (m_rem > 0) && !abort && mem_ready;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rem  <= 0;
            m_next <= 0;
            m_alt  <= 1'b0;
            m_tail <= 1'b0;
            m_pv   <= 1'b0;
            m_pi   <= 0;
            m_pl   <= 1'b0;
            m_dn   <= 1'b0;
        end else begin
            m_pv <= m_xfer;
            m_pl <= m_xfer && (m_rem == 1);
            if (m_xfer) m_pi <= m_next;
            if ((m_rem > 0 || m_tail) && abort) begin
                m_rem  <= 0;
                m_tail <= 1'b0;
                m_dn   <= 1'b0;
            end else if (m_rem > 0) begin
                if (m_xfer) begin
                    m_next <= m_next + 1;
                    m_rem  <= m_rem - 1;
                    m_tail <= (m_rem == 1);
                    m_dn   <= (m_rem == 1);
                end else begin
                    m_dn <= 1'b0;
                end
            end else if (m_tail) begin
                m_tail <= 1'b0;
                m_dn   <= 1'b0;
            end else if (start) begin
                m_rem  <= clamp_len(int'(len));
                m_next <= 0;
                m_alt  <= alt_sel;
                m_dn   <= (len == 0);
            end else begin
                m_dn <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("mdl_ren", mem_ren, (m_rem > 0) && !abort);
            chk("mdl_addr1", mem_addr1, (m_rem > 0) ? addr_a(m_next) : 0);
            chk("mdl_addr2", mem_addr2, (m_rem > 0) ? addr_b(m_next, m_alt) : 0);
            chk("mdl_busy", busy, (m_rem > 0) || m_tail);
            chk("mdl_done", done, m_dn && !(abort && m_tail));
            chk("mdl_rd_valid", rd_valid, m_pv);
            if (m_pv) begin
                chk("mdl_rd_index", rd_index, m_pi);
                chk("mdl_rd_last", rd_last, m_pl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    int n_xfer;
    int done_cyc;
    int la1, la2;
    int exp_a1 [5] = '{0, 1, 1, 1, 2};
    int exp_rv [5] = '{0, 1, 0, 0, 1};
    bit rdy_seq[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; alt_sel = 1'b0; abort = 1'b0; mem_ready = 1'b1;
        #3;
        chk("rst_ren", mem_ren, 0);
        chk("rst_addr1", mem_addr1, 0);
        chk("rst_addr2", mem_addr2, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_index", rd_index, 0);
        chk("rst_rd_last", rd_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        step();
        rst = 1'b0;
        step();

        // len=4, vec2
        start = 1'b1; len = 9'd4; alt_sel = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("l4_addr1", mem_addr1, i);
            chk("l4_addr2", mem_addr2, 256 + i);
            if (i > 0) chk("l4_rd_index", rd_index, i - 1);
            step();
        end
        @(negedge clk);
        chk("l4_rd_valid", rd_valid, 1);
        chk("l4_rd_index3", rd_index, 3);
        chk("l4_rd_last", rd_last, 1);
        chk("l4_done", done, 1);
        step();
        @(negedge clk);
        chk("l4_busy_after", busy, 0);
        chk("l4_done_after", done, 0);
        step();

        // len=264, vec3: boundary addresses and done timing
        start = 1'b1; len = 9'd264; alt_sel = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 264; c++) begin
            @(negedge clk);
            if (c == 255) begin
                chk("l264_a1_255", mem_addr1, 255);
                chk("l264_a2_255", mem_addr2, 767);
            end
            if (c == 256) begin
                chk("l264_a1_256", mem_addr1, 768);
                chk("l264_a2_256", mem_addr2, 784);
            end
            if (c == 263) begin
                chk("l264_a1_263", mem_addr1, 775);
                chk("l264_a2_263", mem_addr2, 791);
            end
            step();
        end
        @(negedge clk);
        chk("l264_done", done, 1);
        chk("l264_last", rd_last, 1);
        step();

        // len=300 clamps to 264
        start = 1'b1; len = 9'd300; alt_sel = 1'b1;
        step();
        start = 1'b0;
        n_xfer = 0; done_cyc = 0; la1 = -1; la2 = -1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (mem_ren && mem_ready) begin
                n_xfer++;
                la1 = int'(mem_addr1);
                la2 = int'(mem_addr2);
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            step();
        end
        chk("clamp_xfers", n_xfer, 264);
        chk("clamp_last_a1", la1, 775);
        chk("clamp_last_a2", la2, 791);
        chk("clamp_done_cyc", done_cyc, 265);
        step();

        // len=0
        start = 1'b1; len = 9'd0;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("l0_done", done, 1);
        chk("l0_busy", busy, 0);
        chk("l0_ren", mem_ren, 0);
        step();
        @(negedge clk);
        chk("l0_done_once", done, 0);
        chk("l0_busy2", busy, 0);
        step();

        // len=3 with back-pressure
        start = 1'b1; len = 9'd3; alt_sel = 1'b0;
        step();
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            mem_ready = rdy_seq[c];
            @(negedge clk);
            chk("bp_addr1", mem_addr1, exp_a1[c]);
            chk("bp_rd_valid", rd_valid, exp_rv[c]);
            if (c == 4) chk("bp_rd_index1", rd_index, 1);
            step();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("bp_rd_index2", rd_index, 2);
        chk("bp_rd_last", rd_last, 1);
        chk("bp_done", done, 1);
        step();

        // abort on the third issue cycle of len=10
        start = 1'b1; len = 9'd10; alt_sel = 1'b0;
        step();
        start = 1'b0;
        step();
        step();
        abort = 1'b1;
        @(negedge clk);
        chk("ab_ren", mem_ren, 0);
        step();
        abort = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("ab_busy", busy, 0);
            chk("ab_done", done, 0);
            chk("ab_rd_valid", rd_valid, 0);
            step();
        end
        start = 1'b1; len = 9'd2; alt_sel = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        chk("ab_restart_a1", mem_addr1, 0);
        chk("ab_restart_a2", mem_addr2, 512);
        step();
        step();
        @(negedge clk);
        chk("ab_restart_done", done, 1);
        step();

        // start ignored while busy, then asynchronous reset mid-ISSUE
        start = 1'b1; len = 9'd10; alt_sel = 1'b0;
        step();
        len = 9'd5; alt_sel = 1'b1;
        step();
        step();
        start = 1'b0;
        @(negedge clk);
        chk("ign_addr1", mem_addr1, 2);
        chk("ign_addr2", mem_addr2, 258);
        step();
        #1 rst = 1'b1;
        #1;
        chk("arst_ren", mem_ren, 0);
        chk("arst_addr1", mem_addr1, 0);
        chk("arst_addr2", mem_addr2, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rd_valid", rd_valid, 0);
        chk("arst_rd_index", rd_index, 0);
        chk("arst_done", done, 0);
        step();
        rst = 1'b0;
        step();
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ren", mem_ren, 0);
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
